imem_responder: RTL and testbench

Instruction-memory responder: the memory end of the fetch request/response channel, serving 32-bit instruction words to the fetch stage after a programmable wait-state latency. It sits between the fetch stage, which issues word-aligned PC addresses, and a program-loader write port that fills memory before and during execution. It gives the pipeline a realistic multi-cycle fetch, so the fetch stage's stall handling can be exercised cycle-accurately.

---
 rtl/imem_responder.sv | 125 ++++++++++++
 tb/tb_imem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves word-aligned fetches after LATENCY wait states,
// with a loader write port that stays active in every state.
module imem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instruction,
  output logic        rsp_error,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // An address is usable only when word-aligned and inside the array.
  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && ((addr >> (AW + 2)) == 32'd0);
  endfunction

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic [31:0]     addr_r;
  logic [31:0]     rsp_instruction_r;
  logic            rsp_error_r;
  logic            accept_s;
  logic            capture_s;
  logic            rd_ok_s;
  logic [31:0]     rd_word_s;
  logic [31:0]     mem_r [DEPTH] = '{default: 32'd0};

  assign rd_ok_s   = addr_ok(addr_r);
  assign rd_word_s = mem_r[addr_r[AW+1:2]];

  // Next-state and control decode for the request/response sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          cnt_s    = CW'(LATENCY - 1);
          state_s  = S_WAIT;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == CW'(0)) begin
          capture_s = 1'b1;
          state_s   = S_RESP;
        end else begin
          cnt_s     = cnt_r - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = CW'(0);
      end
    endcase
  end

  // State, latched address and response registers; reset drops any in-flight fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= S_IDLE;
      cnt_r             <= CW'(0);
      addr_r            <= 32'd0;
      rsp_instruction_r <= 32'd0;
      rsp_error_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        addr_r <= req_addr;
      end
      // The capture reads the pre-edge array, so a same-edge write returns old data.
      if (capture_s) begin
        rsp_instruction_r <= rd_ok_s ? rd_word_s : 32'd0;
        rsp_error_r       <= ~rd_ok_s;
      end
    end
  end

  // Loader writes; memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en && addr_ok(wr_addr)) begin
      mem_r[wr_addr[AW+1:2]] <= wr_data;
    end
  end

  assign req_ready       = (state_r == S_IDLE);
  assign rsp_valid       = (state_r == S_RESP);
  assign busy            = (state_r != S_IDLE);
  assign rsp_instruction = rsp_instruction_r;
  assign rsp_error       = rsp_error_r;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: instance a uses LATENCY=2 for the main scenarios, instance b uses
// LATENCY=1 for the back-to-back spacing check.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset;
  int          total = 0;
  int          passed = 0;
  int          failed = 0;
  int          cyc = 0;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_error;
  logic        a_wr_en, a_busy;
  logic [31:0] a_req_addr, a_rsp_instruction, a_wr_addr, a_wr_data;

  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_error;
  logic        b_wr_en, b_busy;
  logic [31:0] b_req_addr, b_rsp_instruction, b_wr_addr, b_wr_data;

  imem_responder #(.DEPTH(256), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_instruction(a_rsp_instruction), .rsp_error(a_rsp_error),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .busy(a_busy)
  );

  imem_responder #(.DEPTH(256), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_instruction(b_rsp_instruction), .rsp_error(b_rsp_error),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .busy(b_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full LATENCY=2 read with rsp_ready held high, checking every cycle of the timeline.
  task automatic read_a(input string tag, input logic [31:0] addr,
                        input logic [31:0] exp_data, input logic exp_err);
    a_req_valid = 1'b1; a_req_addr = addr; a_rsp_ready = 1'b1;
    tick();
    a_req_valid = 1'b0;
    check({tag, "_busy_t0"}, a_busy, 32'd1);
    check({tag, "_rdy_t0"}, a_req_ready, 32'd0);
    tick();
    check({tag, "_vld_t1"}, a_rsp_valid, 32'd0);
    tick();
    check({tag, "_vld_t2"}, a_rsp_valid, 32'd1);
    check({tag, "_data"}, a_rsp_instruction, exp_data);
    check({tag, "_err"}, a_rsp_error, 32'(exp_err));
    tick();
    check({tag, "_vld_t3"}, a_rsp_valid, 32'd0);
    check({tag, "_rdy_t3"}, a_req_ready, 32'd1);
  endtask

  task automatic write_a(input logic [31:0] addr, input logic [31:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
    tick();
    a_wr_en = 1'b0;
  endtask

  initial begin
    int t_first;
    int t_prev;
    reset = 1'b1;
    a_req_valid = 1'b0; a_req_addr = 32'd0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = 32'd0; b_rsp_ready = 1'b0;
    b_wr_en = 1'b0; b_wr_addr = 32'd0; b_wr_data = 32'd0;
    // Write during reset must still land in memory.
    a_wr_en = 1'b1; a_wr_addr = 32'h8; a_wr_data = 32'h0000_1234;
    tick();
    reset = 1'b0; a_wr_en = 1'b0;
    check("rst_ready", a_req_ready, 32'd1);
    check("rst_valid", a_rsp_valid, 32'd0);
    check("rst_instr", a_rsp_instruction, 32'd0);
    check("rst_error", a_rsp_error, 32'd0);
    check("rst_busy", a_busy, 32'd0);

    read_a("basic", 32'h8, 32'h0000_1234, 1'b0);

    // Backpressure, with req_addr wiggled while busy and a write during RESP.
    a_req_valid = 1'b1; a_req_addr = 32'h8; a_rsp_ready = 1'b0;
    tick();
    a_req_valid = 1'b0; a_req_addr = 32'h6;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      a_wr_en = (i == 1); a_wr_addr = 32'h8; a_wr_data = 32'h0000_9999;
      check("bp_valid", a_rsp_valid, 32'd1);
      check("bp_data", a_rsp_instruction, 32'h0000_1234);
      check("bp_ready", a_req_ready, 32'd0);
      tick();
    end
    a_wr_en = 1'b0;
    check("bp_still", a_rsp_valid, 32'd1);
    a_rsp_ready = 1'b1;
    tick();
    check("bp_hs_valid", a_rsp_valid, 32'd0);
    check("bp_hs_ready", a_req_ready, 32'd1);

    read_a("misalign", 32'h6, 32'd0, 1'b1);
    read_a("range", 32'h400, 32'd0, 1'b1);

    // Write on the capture edge is not visible to that read.
    write_a(32'h10, 32'hAAAA_AAAA);
    a_req_valid = 1'b1; a_req_addr = 32'h10; a_rsp_ready = 1'b1;
    tick();
    a_req_valid = 1'b0;
    tick();
    a_wr_en = 1'b1; a_wr_addr = 32'h10; a_wr_data = 32'h5555_5555;
    tick();
    a_wr_en = 1'b0;
    check("coll_valid", a_rsp_valid, 32'd1);
    check("coll_old", a_rsp_instruction, 32'hAAAA_AAAA);
    tick();
    // Misaligned and out-of-range writes must be dropped, not alias word 4.
    write_a(32'h12, 32'hDEAD_0001);
    write_a(32'h410, 32'hDEAD_0002);
    read_a("coll_new", 32'h10, 32'h5555_5555, 1'b0);

    // Reset during WAIT.
    a_req_valid = 1'b1; a_req_addr = 32'h10; a_rsp_ready = 1'b1;
    tick();
    a_req_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_valid", a_rsp_valid, 32'd0);
    check("rw_ready", a_req_ready, 32'd1);
    check("rw_busy", a_busy, 32'd0);
    tick();
    tick();
    check("rw_nostale", a_rsp_valid, 32'd0);

    // Reset during RESP.
    a_req_valid = 1'b1; a_req_addr = 32'h10; a_rsp_ready = 1'b0;
    tick();
    a_req_valid = 1'b0;
    tick();
    tick();
    check("rr_inresp", a_rsp_valid, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_valid", a_rsp_valid, 32'd0);
    check("rr_ready", a_req_ready, 32'd1);
    check("rr_busy", a_busy, 32'd0);
    check("rr_instr", a_rsp_instruction, 32'd0);
    tick();
    check("rr_nostale", a_rsp_valid, 32'd0);

    read_a("keep10", 32'h10, 32'h5555_5555, 1'b0);
    read_a("keep08", 32'h8, 32'h0000_9999, 1'b0);

    // LATENCY=1 back-to-back fetches: responses 3 cycles apart, in order.
    for (int k = 0; k < 3; k++) begin
      b_wr_en = 1'b1; b_wr_addr = 32'(k * 4); b_wr_data = 32'h1111_1111 * 32'(k + 1);
      tick();
    end
    b_wr_en = 1'b0;
    b_rsp_ready = 1'b1; b_req_valid = 1'b1;
    t_first = 0; t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      b_req_addr = 32'(k * 4);
      for (int n = 0; n < 10 && !b_rsp_valid; n++) tick();
      check("b2b_seen", b_rsp_valid, 32'd1);
      check("b2b_data", b_rsp_instruction, 32'h1111_1111 * 32'(k + 1));
      if (k == 0) t_first = cyc;
      else check("b2b_gap", 32'(cyc - t_prev), 32'd3);
      t_prev = cyc;
      if (k == 2) b_req_valid = 1'b0;
      tick();
    end
    check("b2b_span", 32'(t_prev - t_first), 32'd6);
    check("b2b_idle", b_req_ready, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
